rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-way decoded resource (e.g. a select bus or LED line bank) among 8 requesters.
- Owns the grant state machine, the rotating priority pointer and a hold-time watchdog.
- Drives a one-hot grant through an enabled 3-to-8 decoder, which is the block's datapath.
- Sits between the requester logic and the shared decoded select lines.

---
 rtl/rr_arb_pkg.sv | 27 ++
 rtl/onehot_dec3to8.sv | 13 +
 rtl/rr_arbiter8.sv | 89 ++++++++
 tb/tb_rr_arbiter8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the state encoding and the pointer-relative priority search.
package rr_arb_pkg;

  localparam int unsigned N_REQ          = 8;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned DefaultMaxHold = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StRel   = 2'b10
  } arb_state_e;

  // First set bit scanning ptr, ptr+1, ... ptr+7 (mod 8); scanning offsets high to low
  // lets the smallest offset win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (vec[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Enabled 3-to-8 one-hot decoder; all-zero output when disabled.
module onehot_dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a hold-time watchdog.
// Grant index and valid are registered; the one-hot grant is decoded from them.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DefaultMaxHold,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          idx_d   = rr_pick(req, ptr_q);
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (done || !req[idx_q] || hold_q == HoldLast) begin
          state_d   = StRel;
          valid_d   = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          // Watchdog flagged only when nothing else caused the release.
          timeout_d = !done && req[idx_q];
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      StRel: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  onehot_dec3to8 u_dec (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected grants/releases are queued by the stimulus
// and retired by a negedge monitor as the DUT raises and drops gnt_valid.
module tb_rr_arbiter8;

  typedef struct {
    logic to;
    int   len;
  } rel_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       done = 1'b0;
  logic [7:0] req  = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_gnt_q[$];
  rel_t       exp_rel_q[$];

  logic prev_valid = 1'b0;
  int   hold_len   = 0;

  rr_arbiter8 #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic v);
    int n = 0;
    while (gnt_valid !== v && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(gnt_valid), 32'(v));
  endtask

  task automatic push_grant(input logic [2:0] idx, input logic to, input int len);
    rel_t r;
    r.to  = to;
    r.len = len;
    exp_gnt_q.push_back(idx);
    exp_rel_q.push_back(r);
  endtask

  // Grant expected at idx, held for 'hold' cycles, then released by done.
  task automatic serve(input logic [2:0] idx, input int hold);
    push_grant(idx, 1'b0, hold);
    wait_valid(1'b1);
    repeat (hold - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Monitor: retire one expected grant per rising gnt_valid, one release per falling edge.
  always @(negedge clk) begin
    logic [2:0] e;
    rel_t       r;
    if (gnt_valid === 1'b1 && prev_valid === 1'b0) begin
      hold_len = 0;
      if (exp_gnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got idx %0d expected none", gnt_idx);
      end else begin
        e = exp_gnt_q.pop_front();
        chk("grant_onehot", 32'(gnt), 32'(8'h01 << e));
        chk("grant_idx", 32'(gnt_idx), 32'(e));
      end
    end
    if (gnt_valid === 1'b1) hold_len++;
    if (gnt_valid === 1'b0 && prev_valid === 1'b1) begin
      if (exp_rel_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_release: got release expected none");
      end else begin
        r = exp_rel_q.pop_front();
        chk("release_timeout", 32'(timeout), 32'(r.to));
        if (r.len != 0) chk("hold_len", 32'(hold_len), 32'(r.len));
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    // Single request, latency 1, done at cycle 3
    req = 8'h04;
    push_grant(3'd2, 1'b0, 3);
    tick();
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_valid", 32'(gnt_valid), 32'h0);
    chk("single_rel_idx_hold", 32'(gnt_idx), 32'd2);
    chk("single_rel_timeout", 32'(timeout), 32'h0);
    req = 8'h00;
    tick();

    // Reset mid-grant
    req = 8'h10;
    push_grant(3'd4, 1'b0, 2);
    wait_valid(1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_valid", 32'(gnt_valid), 32'h0);
    chk("midrst_idx", 32'(gnt_idx), 32'h0);
    push_grant(3'd4, 1'b0, 1);
    tick();
    chk("postrst_gnt", 32'(gnt), 32'h10);

    // Withdrawal releases on the next edge without timeout
    req = 8'h00;
    tick();
    chk("withdraw_valid", 32'(gnt_valid), 32'h0);
    chk("withdraw_timeout", 32'(timeout), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Rotation from ptr=0; hold 4 makes done coincide with the watchdog limit
    req = 8'hFF;
    for (int i = 0; i < 9; i++) serve(3'(i % 8), (i % 4) + 1);

    // Pointer wrap: ptr=1 -> idx5 -> ptr=6 -> idx0 -> ptr=1 -> idx5
    req = 8'h20;
    serve(3'd5, 2);
    req = 8'h21;
    serve(3'd0, 1);
    serve(3'd5, 1);

    // Watchdog: held exactly 4 cycles, timeout pulse, regrant two cycles later
    req = 8'h80;
    push_grant(3'd7, 1'b1, 4);
    wait_valid(1'b1);
    wait_valid(1'b0);
    chk("wd_timeout_pulse", 32'(timeout), 32'h1);
    push_grant(3'd7, 1'b0, 1);
    tick();
    chk("wd_gap_valid", 32'(gnt_valid), 32'h0);
    chk("wd_timeout_clear", 32'(timeout), 32'h0);
    tick();
    chk("wd_regrant_gnt", 32'(gnt), 32'h80);
    req = 8'h00;
    tick();
    chk("wd_withdraw_timeout", 32'(timeout), 32'h0);

    // done in IDLE is ignored
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_done_valid", 32'(gnt_valid), 32'h0);
    chk("idle_done_timeout", 32'(timeout), 32'h0);
    tick();
    chk("idle_done_valid2", 32'(gnt_valid), 32'h0);
    req = 8'h02;
    serve(3'd1, 2);
    req = 8'h00;
    repeat (4) tick();

    chk("grant_queue_empty", 32'(exp_gnt_q.size()), 32'h0);
    chk("release_queue_empty", 32'(exp_rel_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
